// File: rtl/wide_add_sequencer_pkg.sv
// Shared widths, opcode values and FSM encoding for the multi-precision add/sub engine.
package wide_add_sequencer_pkg;
  localparam int WORD_W = 16;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/wide_add_sequencer_adder.sv
// 16-bit combinational ripple-carry adder shared by every word of the sequencer.
module wide_add_sequencer_adder
  import wide_add_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  logic [WORD_W:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < WORD_W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[WORD_W];
endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision A+B+C / A-B: one 16-bit adder reused per word, LSW first,
// with the carry chained through a register between words.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                        iClk,
  input  logic                        iReset,
  input  logic                        iValid,
  output logic                        oReady,
  input  logic                        iSub,
  input  logic                        iC,
  input  logic [WORD_W*NUM_WORDS-1:0] iA,
  input  logic [WORD_W*NUM_WORDS-1:0] iB,
  output logic                        oValid,
  input  logic                        iAck,
  output logic [WORD_W*NUM_WORDS-1:0] oResult,
  output logic                        oCarryout,
  output logic                        oOverflow,
  output logic                        oZero
);
  localparam int CW = $clog2(NUM_WORDS);

  state_e                              state_q, state_d;
  logic [CW-1:0]                       cnt_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0]    a_q, b_q, res_q;
  logic                                carry_q, zacc_q;
  logic                                cout_q, ovf_q, zero_q;
  logic [WORD_W-1:0]                   a_w, b_w, sum_w;
  logic                                cout_w, last, accept;

  assign a_w    = a_q[cnt_q];
  assign b_w    = b_q[cnt_q];
  assign last   = (cnt_q == CW'(NUM_WORDS - 1));
  assign accept = iValid & oReady;

  wide_add_sequencer_adder u_m16_adder (
    .a   (a_w),
    .b   (b_w),
    .cin (carry_q),
    .sum (sum_w),
    .cout(cout_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last)   state_d = DONE;
      DONE:    if (iAck)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          // Subtract is A + ~B + 1: invert B once here and seed the carry.
          a_q     <= iA;
          b_q     <= (iSub == ALU_OP_SUB) ? ~iB : iB;
          carry_q <= (iSub == ALU_OP_SUB) ? 1'b1 : iC;
          cnt_q   <= '0;
          zacc_q  <= 1'b1;
        end
        RUN: begin
          res_q[cnt_q] <= sum_w;
          carry_q      <= cout_w;
          cnt_q        <= cnt_q + 1'b1;
          zacc_q       <= zacc_q & (sum_w == '0);
          if (last) begin
            cout_q <= cout_w;
            ovf_q  <= (a_w[WORD_W-1] == b_w[WORD_W-1]) & (sum_w[WORD_W-1] != a_w[WORD_W-1]);
            zero_q <= zacc_q & (sum_w == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign oReady    = (state_q == IDLE);
  assign oValid    = (state_q == DONE);
  assign oResult   = res_q;
  assign oCarryout = cout_q;
  assign oOverflow = ovf_q;
  assign oZero     = zero_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench: driver pushes model results, monitor checks them on the output handshake.
module tb_wide_add_sequencer;
  localparam int NW = 4;
  localparam int W  = 16 * NW;
  localparam logic signed [W+1:0] MAXS = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MINS = {3'b111, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  logic         clk, rst, ivalid, oready, isub, ic, ovalid, iack, ocarry, oovf, ozero;
  logic [W-1:0] ia, ib, ores;

  exp_t exp_q[$];
  int   checks = 0, fails = 0, cyc = 0;
  bit   ack_rand = 0, ack_lvl = 1;

  wide_add_sequencer #(.NUM_WORDS(NW)) dut (
    .iClk(clk), .iReset(rst), .iValid(ivalid), .oReady(oready), .iSub(isub), .iC(ic),
    .iA(ia), .iB(ib), .oValid(ovalid), .iAck(iack), .oResult(ores),
    .oCarryout(ocarry), .oOverflow(oovf), .oZero(ozero)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: ack level changes just after each rising edge.
  initial begin
    iack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      iack = ack_rand ? ($urandom_range(0, 3) != 0) : ack_lvl;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: full-precision integer arithmetic, overflow as out-of-range signed result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic c);
    exp_t m;
    logic [W:0] u;
    logic signed [W+1:0] s;
    if (sub) begin
      m.res  = a - b;
      m.cout = (a >= b);
      s = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
    end else begin
      u = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      m.res  = u[W-1:0];
      m.cout = u[W];
      s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, c});
    end
    m.ovf  = (s > MAXS) || (s < MINS);
    m.zero = (m.res == '0);
    m.acc  = 0;
    return m;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic c);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!oready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("issue_ready", W'(oready), W'(1));
    if (!oready) return;
    ia = a; ib = b; isub = sub; ic = c; ivalid = 1'b1;
    e = model(a, b, sub, c);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    ivalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !oready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", W'(exp_q.size()), W'(0));
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    logic [31:0]  r;
    for (int i = 0; i < NW; i++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0: v[16*i +: 16] = 16'h0000;
        1: v[16*i +: 16] = 16'hFFFF;
        2: v[16*i +: 16] = 16'h7FFF;
        3: v[16*i +: 16] = 16'h8000;
        default: v[16*i +: 16] = r[15:0];
      endcase
    end
    return v;
  endfunction

  // Monitor: latency on oValid rise, full result compare on the handshake.
  initial begin
    exp_t e;
    logic pv = 1'b0;
    forever begin
      @(negedge clk);
      if (ovalid && !pv) begin
        if (exp_q.size() == 0) chk("spurious_valid", W'(ovalid), W'(0));
        else                   chk("latency", W'(cyc - exp_q[0].acc), W'(NW));
      end
      if (ovalid && iack && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", ores, e.res);
        chk("carryout", W'(ocarry), W'(e.cout));
        chk("overflow", W'(oovf), W'(e.ovf));
        chk("zero", W'(ozero), W'(e.zero));
      end
      pv = ovalid;
    end
  end

  initial begin
    logic [W-1:0] held;
    int t;
    rst = 1; ivalid = 0; isub = 0; ic = 0; ia = '0; ib = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", W'(oready), W'(1));
    chk("rst_valid", W'(ovalid), W'(0));
    chk("rst_result", ores, '0);
    chk("rst_flags", W'({ocarry, oovf, ozero}), W'(0));
    rst = 0;

    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    issue(64'h0, 64'h1, 1'b1, 1'b0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    issue('1, '1, 1'b0, 1'b1);
    issue(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
    drain();

    // Reset while word 2 is in flight.
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 0;
    chk("midrun_rst_ready", W'(oready), W'(1));
    chk("midrun_rst_valid", W'(ovalid), W'(0));
    chk("midrun_rst_result", ores, '0);
    issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    drain();

    // Stall in DONE with requests offered.
    ack_lvl = 0;
    @(negedge clk);
    issue(64'hDEAD_BEEF_0123_4567, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b1);
    t = 0;
    while (!ovalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_reach_done", W'(ovalid), W'(1));
    held = exp_q.size() != 0 ? exp_q[0].res : '0;
    repeat (5) begin
      ia = '1; ib = '1; isub = 1'b0; ic = 1'b1; ivalid = 1'b1;
      @(negedge clk);
      chk("stall_valid", W'(ovalid), W'(1));
      chk("stall_ready", W'(oready), W'(0));
      chk("stall_result", ores, held);
    end
    ivalid = 1'b0;
    ack_lvl = 1;
    t = 0;
    while (ovalid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("stall_release_ready", W'(oready), W'(1));
    repeat (6) @(negedge clk);
    chk("stall_req_ignored", W'({ovalid, oready}), W'(2'b01));

    ack_rand = 1;
    for (int n = 0; n < 40; n++)
      issue(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    ack_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
